spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
SPI mode-0 master that serialises bytes from a valid/ready stream onto spi_sclk/spi_mosi/spi_cs_n, MSB first. It is the controller-side driver for the on-chip SPI slave receiver (slave oversamples SCLK/CS with a 2-FF synchroniser on the same clk). It supports single-byte and burst (CS held low) transfers. Optional MISO capture returns received bytes.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range ≥4, so the slave's synchroniser sees every level.
CS_SETUP, 4, clk cycles from cs_n falling to the first SCLK rise; legal range ≥3.
CS_HOLD, 4, clk cycles from the last SCLK fall to cs_n rising, and also the minimum cs_n high time before the next frame.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a byte; transfer occurs when tx_valid && tx_ready
tx_last  in  1  sampled with the byte; 1 = release CS after this byte
spi_sclk  out  1  serial clock; idles low (CPOL=0)
spi_mosi  out  1  serial data out; changes only while SCLK is low
spi_cs_n  out  1  chip select, active low
spi_miso  in  1  serial data in (used only with the optional feature)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the final SCLK fall of each byte

Behaviour:
- Reset values (async, on rst_n low at any time, including mid-frame): sclk=0, cs_n=1, mosi=0, done=0, busy=0, tx_ready=1. State returns to IDLE and all counters clear. The partial frame is abandoned, with no glitch beyond cs_n rising.
- All SPI outputs are registered. tx_ready is 1 only in IDLE and BURST_WAIT.
- States:
  - IDLE: on accept, latch data and last, cs_n<=0, mosi<=data[7], go to SETUP.
  - SETUP: count CS_SETUP cycles, then go to SHIFT_HI with sclk<=1.
  - SHIFT_HI: hold CLK_DIV cycles, then sclk<=0.
    - bit_cnt!=0: mosi<=next bit, go to SHIFT_LO.
    - bit_cnt==0: pulse done; go to HOLD if last, else BURST_WAIT.
  - SHIFT_LO: hold CLK_DIV cycles, then go to SHIFT_HI with sclk<=1.
  - BURST_WAIT: cs_n stays 0, sclk stays 0. On accept, latch data and last, mosi<=data[7], hold CLK_DIV cycles low, then go to SHIFT_HI. The wait is unbounded.
  - HOLD: CS_HOLD cycles, then cs_n<=1, go to GAP.
  - GAP: CS_HOLD cycles with cs_n=1, then go to IDLE. tx_ready stays 0 during GAP.
- Counters:
  - bit_cnt is 3 bits and counts 7→0.
  - div_cnt has width $clog2(max(CLK_DIV,CS_SETUP,CS_HOLD)+1) and is reloaded on every state change.
- Single-byte latency: accept at cycle 0; cs_n low at cycle 1; first SCLK rise at 1+CS_SETUP; 8 bits take 16*CLK_DIV-CLK_DIV cycles until the last fall; cs_n high CS_HOLD cycles later.
- tx_valid during a non-ready state is ignored; the byte is held by the upstream, and no data is lost.
- tx_data and tx_last changing after accept have no effect.

Optional Feature:
SPI_MASTER_RX_EN:
- Defined: adds ports rx_data out 8 and rx_valid out 1 (reset 0x00/0).
  - spi_miso is sampled on each SCLK rise into a shift register.
  - rx_data updates and rx_valid pulses in the same cycle as done.
- Undefined: the ports are absent and spi_miso is unused.

Decomposition:
- Package spi_pkg:
  - spi_master_state_t enum (IDLE, SETUP, SHIFT_HI, SHIFT_LO, BURST_WAIT, HOLD, GAP).
  - SPI_DATA_W=8.
  - SPI_MIN_CLK_DIV=4.
- Sub-module spi_clk_div: loadable down-counter with a terminal-count pulse, reused for the setup, half-period, hold and gap timing.

Test Plan:
- CLK_DIV=4, send 0xA5 with last=1 → 8 SCLK rises; mosi at the rises = 1,0,1,0,0,1,0,1; cs_n low for 4+60+4 cycles; done pulses once; tx_ready low until GAP ends.
- Burst 0x3C (last=0) then 0xC3 (last=1) → cs_n stays low across both bytes, 16 rises total, two done pulses; loopback into the SPI slave model yields rx_data 0x3C then 0xC3.
- Burst with 20-cycle tx_valid gap after byte 1 → sclk=0 and cs_n=0 throughout BURST_WAIT; second byte is correct.
- rst_n asserted after the 3rd SCLK rise → same-cycle cs_n=1, sclk=0, busy=0; next frame 0xFF transmits cleanly.
- Back-to-back single frames 0x01, 0x80 → cs_n high ≥CS_HOLD cycles between them; slave model detects two cs falls.
- With SPI_MASTER_RX_EN, miso driven 0x5A aligned to the rises → rx_data=0x5A, with rx_valid coincident with done.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master transmitter.
//   spi_master_state_t : master FSM state encoding
//   SPI_DATA_W         : bits per SPI frame byte
//   SPI_MIN_CLK_DIV    : smallest legal SCLK half-period, in clk cycles
//   max3()             : helper that sizes the shared timing counter
package spi_pkg;

   localparam int SPI_DATA_W      = 8;
   localparam int SPI_MIN_CLK_DIV = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      BURST_WAIT,
      HOLD,
      GAP
   } spi_master_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: loadable down-counter with a one-cycle terminal-count pulse.
// One instance times the CS setup, SCLK half-periods, CS hold and CS gap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with load_val (arms the terminal count)
//   load_val   : cycles-minus-one for the interval being started
//   tc         : high for exactly one cycle, load_val+1 cycles after load
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;

   // The armed flag turns the zero level into a single pulse, so a state
   // that waits on tc can never see a stale terminal count.
   assign tc = armed_q && (cnt_q == '0);

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (load) begin
         cnt_d   = load_val;
         armed_d = 1'b1;
      end else if (tc) begin
         armed_d = 1'b0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, fed by a
// valid/ready byte stream. tx_last=0 keeps CS low for a burst.
// Optional build macro SPI_MASTER_RX_EN adds MISO capture (rx_data/rx_valid).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tx_data/valid/ready   : byte stream in; transfer on tx_valid && tx_ready
//   tx_last               : captured with the byte; 1 releases CS afterwards
//   spi_sclk/mosi/cs_n    : registered SPI outputs
//   spi_miso              : serial in (only used with SPI_MASTER_RX_EN)
//   busy                  : high whenever the FSM is not IDLE
//   done                  : one-cycle pulse after the last SCLK fall of a byte
//   rx_data, rx_valid     : (SPI_MASTER_RX_EN) received byte, pulses with done
// Parameters: CLK_DIV (>=4) SCLK half-period, CS_SETUP (>=3) CS fall to first
// rise, CS_HOLD last fall to CS rise and minimum CS high time.
module spi_master_tx #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       tx_last,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   input  logic       spi_miso,
   output logic       busy,
   output logic       done
`ifdef SPI_MASTER_RX_EN
   ,
   output logic [7:0] rx_data,
   output logic       rx_valid
`endif
);

   import spi_pkg::*;

   localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);

   spi_master_state_t state_q, state_d;

   logic [SPI_DATA_W-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  done_q, done_d;

   logic             accept;
   logic             div_load;
   logic [CNT_W-1:0] div_load_val;
   logic             div_tc;

   assign tx_ready = (state_q == IDLE) || (state_q == BURST_WAIT);
   assign busy     = (state_q != IDLE);
   assign accept   = tx_valid && tx_ready;

   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;
   assign done     = done_q;

   // Every state change restarts the timer with the length of the new state.
   assign div_load = (state_d != state_q);

   always_comb begin
      div_load_val = '0;
      case (state_d)
         SETUP:              div_load_val = CNT_W'(CS_SETUP - 1);
         SHIFT_HI, SHIFT_LO: div_load_val = CNT_W'(CLK_DIV - 1);
         HOLD, GAP:          div_load_val = CNT_W'(CS_HOLD - 1);
         default:            div_load_val = '0;
      endcase
   end

   spi_clk_div #(
      .CNT_W   (CNT_W)
   ) u_clk_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (div_load),
      .load_val(div_load_val),
      .tc      (div_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (accept) state_d = SETUP;
         SETUP:      if (div_tc) state_d = SHIFT_HI;
         SHIFT_HI: begin
            if (div_tc) begin
               if (bit_cnt_q != 3'd0) state_d = SHIFT_LO;
               else if (last_q)       state_d = HOLD;
               else                   state_d = BURST_WAIT;
            end
         end
         SHIFT_LO:   if (div_tc) state_d = SHIFT_HI;
         // A burst byte re-enters through SHIFT_LO: that state already
         // provides the CLK_DIV low period before the first rise.
         BURST_WAIT: if (accept) state_d = SHIFT_LO;
         HOLD:       if (div_tc) state_d = GAP;
         GAP:        if (div_tc) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Output / datapath logic: next values for all registered outputs.
   always_comb begin
      data_d    = data_q;
      last_d    = last_q;
      bit_cnt_d = bit_cnt_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE, BURST_WAIT: begin
            if (accept) begin
               data_d    = tx_data;
               last_d    = tx_last;
               bit_cnt_d = 3'(SPI_DATA_W - 1);
               mosi_d    = tx_data[SPI_DATA_W-1];
               cs_n_d    = 1'b0;
            end
         end
         SETUP, SHIFT_LO: begin
            if (div_tc) sclk_d = 1'b1;
         end
         SHIFT_HI: begin
            if (div_tc) begin
               sclk_d = 1'b0;
               if (bit_cnt_q != 3'd0) begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  mosi_d    = data_q[bit_cnt_q - 3'd1];
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (div_tc) begin
               cs_n_d = 1'b1;
               mosi_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         last_q    <= 1'b0;
         bit_cnt_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         data_q    <= data_d;
         last_q    <= last_d;
         bit_cnt_q <= bit_cnt_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         done_q    <= done_d;
      end
   end

`ifdef SPI_MASTER_RX_EN
   logic [SPI_DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;

   // MISO is taken at the clock edge that raises SCLK; by the final fall the
   // shifter already holds all eight bits, so it is published with done.
   always_comb begin
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = done_d;
      if (sclk_d && !sclk_q) rx_shift_d = {rx_shift_q[SPI_DATA_W-2:0], spi_miso};
      if (done_d)            rx_data_d  = rx_shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
`else
   logic unused_miso;
   assign unused_miso = spi_miso;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
module tb_spi_master_tx;

   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 4;
   localparam int CS_HOLD  = 4;
   localparam int TMO      = 5000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_cs_n;
   logic       spi_miso;
   logic       busy;
   logic       done;
`ifdef SPI_MASTER_RX_EN
   logic [7:0] rx_data;
   logic       rx_valid;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   spi_master_tx #(
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_last (tx_last),
      .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n),
      .spi_miso(spi_miso),
      .busy    (busy),
      .done    (done)
`ifdef SPI_MASTER_RX_EN
      ,
      .rx_data (rx_data),
      .rx_valid(rx_valid)
`endif
   );

   // ---------------- bus monitor (SPI slave view of the wires) ----------------
   logic prev_sclk = 1'b0;
   logic prev_cs_n = 1'b1;
   logic prev_mosi = 1'b0;
   logic seen_rise = 1'b0;
   int   rise_cnt = 0, cs_fall_cnt = 0, done_cnt = 0, cs_low_cyc = 0;
   int   nready_cyc = 0, mosi_viol = 0, sclk_viol = 0, rxv_viol = 0;
   int   cs_high_run = 0, setup_cnt = 0, setup_lat = 0;
   int   gap_q[$];
   bit   bits_q[$];

   always @(negedge clk) begin
      prev_sclk <= spi_sclk;
      prev_cs_n <= spi_cs_n;
      prev_mosi <= spi_mosi;
      if (rst_n) begin
         if (spi_sclk && !prev_sclk) begin
            rise_cnt <= rise_cnt + 1;
            bits_q.push_back(spi_mosi);
            if (!seen_rise) setup_lat <= setup_cnt;
            seen_rise <= 1'b1;
         end
         if (!spi_cs_n && prev_cs_n) begin
            cs_fall_cnt <= cs_fall_cnt + 1;
            gap_q.push_back(cs_high_run);
            setup_cnt <= 1;
            seen_rise <= 1'b0;
         end else if (!spi_cs_n && !spi_sclk && !seen_rise) begin
            setup_cnt <= setup_cnt + 1;
         end
         cs_high_run <= spi_cs_n ? cs_high_run + 1 : 0;
         if (!spi_cs_n)  cs_low_cyc <= cs_low_cyc + 1;
         if (!tx_ready)  nready_cyc <= nready_cyc + 1;
         if (done)       done_cnt   <= done_cnt + 1;
         if (spi_sclk && (spi_mosi !== prev_mosi)) mosi_viol <= mosi_viol + 1;
         if (spi_sclk && spi_cs_n)                 sclk_viol <= sclk_viol + 1;
`ifdef SPI_MASTER_RX_EN
         if (rx_valid !== done) rxv_viol <= rxv_viol + 1;
`endif
      end
   end

   // ---------------- MISO driver: slave shifts miso_byte out, MSB first -------
   logic [7:0] miso_byte = 8'h00;
   logic [2:0] miso_bit = 3'd7;

   always @(negedge clk) begin
      if (!rst_n) begin
         spi_miso <= 1'b0;
         miso_bit <= 3'd7;
      end else if (!spi_cs_n && prev_cs_n) begin
         spi_miso <= miso_byte[7];
         miso_bit <= 3'd6;
      end else if (prev_sclk && !spi_sclk) begin
         spi_miso <= miso_byte[miso_bit];
         miso_bit <= miso_bit - 3'd1;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] got_byte(input int base);
      logic [31:0] b;
      b = 32'hxxxx_xxxx;
      if (bits_q.size() >= base + 8) begin
         b = 32'h0;
         for (int i = 0; i < 8; i++) b[7-i] = bits_q[base+i];
      end
      return b;
   endfunction

   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check("send_ready_wait", n < TMO, 1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~d;      // must not affect the byte in flight
      tx_last  = ~l;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b0 && n < TMO);
      check(tag, n < TMO, 1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < TMO);
      check(tag, n < TMO, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b, r0, d0, f0, c0, q0, g0, bad, n, len;
      logic [7:0] b1, b2;
      logic [7:0] exp_q[$];

      repeat (3) @(negedge clk);
      check("rst_sclk",     spi_sclk, 0);
      check("rst_cs_n",     spi_cs_n, 1);
      check("rst_mosi",     spi_mosi, 0);
      check("rst_done",     done,     0);
      check("rst_busy",     busy,     0);
      check("rst_tx_ready", tx_ready, 1);
`ifdef SPI_MASTER_RX_EN
      check("rst_rx_data",  rx_data,  8'h00);
      check("rst_rx_valid", rx_valid, 0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte 0xA5 with full timing.
      b = bits_q.size(); r0 = rise_cnt; d0 = done_cnt; c0 = cs_low_cyc; q0 = nready_cyc;
      miso_byte = 8'h5A;
      send(8'hA5, 1'b1);
      wait_idle("t1_idle");
      check("t1_byte",      got_byte(b), 8'hA5);
      check("t1_rises",     rise_cnt - r0, 8);
      check("t1_done",      done_cnt - d0, 1);
      check("t1_cs_low",    cs_low_cyc - c0, CS_SETUP + 15*CLK_DIV + CS_HOLD);
      check("t1_not_ready", nready_cyc - q0, CS_SETUP + 15*CLK_DIV + 2*CS_HOLD);
      check("t1_setup",     setup_lat, CS_SETUP);
`ifdef SPI_MASTER_RX_EN
      check("t1_rx_data",   rx_data, 8'h5A);
`endif

      // Burst 0x3C, 0xC3: CS held across both bytes.
      b = bits_q.size(); r0 = rise_cnt; d0 = done_cnt; f0 = cs_fall_cnt;
      miso_byte = 8'h3C;
      send(8'h3C, 1'b0);
      wait_done("t2_done1");
`ifdef SPI_MASTER_RX_EN
      #1 check("t2_rx_data1", rx_data, 8'h3C);
      miso_byte = 8'hC3;
`endif
      send(8'hC3, 1'b1);
      wait_idle("t2_idle");
      check("t2_byte0",   got_byte(b),     8'h3C);
      check("t2_byte1",   got_byte(b + 8), 8'hC3);
      check("t2_rises",   rise_cnt - r0,   16);
      check("t2_done",    done_cnt - d0,   2);
      check("t2_cs_fall", cs_fall_cnt - f0, 1);

      // Burst with a 20-cycle stall in BURST_WAIT.
      b1 = 8'($urandom); b2 = 8'($urandom);
      b = bits_q.size(); f0 = cs_fall_cnt;
      send(b1, 1'b0);
      wait_done("t3_done1");
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      check("t3_wait_lines", bad, 0);
      send(b2, 1'b1);
      wait_idle("t3_idle");
      check("t3_byte0",   got_byte(b),     b1);
      check("t3_byte1",   got_byte(b + 8), b2);
      check("t3_cs_fall", cs_fall_cnt - f0, 1);

      // Asynchronous reset after the third SCLK rise.
      r0 = rise_cnt;
      send(8'h96, 1'b1);
      n = 0;
      while (rise_cnt < r0 + 3 && n < TMO) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("t4_third_rise", n < TMO, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_cs_n", spi_cs_n, 1);
      check("t4_sclk", spi_sclk, 0);
      check("t4_busy", busy,     0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      b = bits_q.size(); r0 = rise_cnt;
      send(8'hFF, 1'b1);
      wait_idle("t4_idle");
      check("t4_byte",  got_byte(b), 8'hFF);
      check("t4_rises", rise_cnt - r0, 8);

      // Back-to-back single frames 0x01, 0x80.
      b = bits_q.size(); f0 = cs_fall_cnt; g0 = gap_q.size();
      send(8'h01, 1'b1);
      send(8'h80, 1'b1);
      wait_idle("t5_idle");
      check("t5_byte0",   got_byte(b),     8'h01);
      check("t5_byte1",   got_byte(b + 8), 8'h80);
      check("t5_cs_fall", cs_fall_cnt - f0, 2);
      check("t5_cs_gap",  (gap_q.size() > g0 + 1) ? (gap_q[g0+1] >= CS_HOLD) : 1'b0, 1);

      // Random frames of 1..3 bytes.
      for (int k = 0; k < 6; k++) begin
         len = $urandom_range(1, 3);
         exp_q.delete();
         for (int j = 0; j < len; j++) exp_q.push_back(8'($urandom));
         miso_byte = 8'($urandom);
         b = bits_q.size(); f0 = cs_fall_cnt; d0 = done_cnt;
         for (int j = 0; j < len; j++) send(exp_q[j], (j == len - 1));
         wait_idle("rnd_idle");
         for (int j = 0; j < len; j++) check("rnd_byte", got_byte(b + 8*j), exp_q[j]);
         check("rnd_cs_fall", cs_fall_cnt - f0, 1);
         check("rnd_done",    done_cnt - d0, len);
`ifdef SPI_MASTER_RX_EN
         check("rnd_rx_data", rx_data, miso_byte);
`endif
      end

      check("mosi_stable_while_sclk_high", mosi_viol, 0);
      check("sclk_only_with_cs",           sclk_viol, 0);
`ifdef SPI_MASTER_RX_EN
      check("rx_valid_with_done",          rxv_viol,  0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
